// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch sequencer: the FSM state
//   encoding, the default HALT instruction word and the default PC width.
//   Imported by the interface and by fetch_ctrl.
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

    // 2-bit state codes, kept as localparams so other blocks (debug taps,
    // trace tools) can decode a state value without the enum type.
    localparam logic [1:0] ST_RUN_ENC   = 2'd0;
    localparam logic [1:0] ST_STALL_ENC = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
    localparam logic [1:0] ST_HALT_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = ST_RUN_ENC,
        ST_STALL = ST_STALL_ENC,
        ST_DRAIN = ST_DRAIN_ENC,
        ST_HALT  = ST_HALT_ENC
    } fetch_state_t;

    // Instruction word that stops fetch.
    localparam logic [31:0] HALT_CODE_DEF = 32'hFC00_0000;

    // Default width of the PC and every address port.
    localparam int PC_WIDTH_DEF  = 6;
    localparam int CNT_WIDTH_DEF = 16;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles everything the fetch sequencer exchanges with the IF stage, the
//   hazard unit and the ID/EX redirect logic.
//   master : the pipeline side (drives PC, instruction, stall, redirects)
//   slave  : fetch_ctrl (drives next_pc, IF/ID control, status, counter)
//   Signals:
//     PCout, PCnext, Instruction      IF stage -> sequencer
//     stall                           hazard unit -> sequencer
//     jump_req/jump_target            ID stage jump
//     branch_req/branch_target        EX stage branch
//     next_pc                         sequencer -> IF jmp_address
//     ifid_write, ifid_flush          IF/ID register control
//     fetch_valid, halted, fetch_count status
// ---------------------------------------------------------------------------
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
    logic [PC_WIDTH-1:0]  PCout;
    logic [PC_WIDTH-1:0]  PCnext;
    logic [31:0]          Instruction;
    logic                 stall;
    logic                 jump_req;
    logic [PC_WIDTH-1:0]  jump_target;
    logic                 branch_req;
    logic [PC_WIDTH-1:0]  branch_target;
    logic [PC_WIDTH-1:0]  next_pc;
    logic                 ifid_write;
    logic                 ifid_flush;
    logic                 fetch_valid;
    logic                 halted;
    logic [CNT_WIDTH-1:0] fetch_count;

    modport master (
        output PCout, PCnext, Instruction, stall,
        output jump_req, jump_target, branch_req, branch_target,
        input  next_pc, ifid_write, ifid_flush, fetch_valid, halted, fetch_count
    );

    modport slave (
        input  PCout, PCnext, Instruction, stall,
        input  jump_req, jump_target, branch_req, branch_target,
        output next_pc, ifid_write, ifid_flush, fetch_valid, halted, fetch_count
    );

endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer. Each cycle picks the address the IF stage
//   loads into its PC (sequential / hold / redirect), drives the IF/ID
//   load-enable and flush, detects the HALT instruction and counts the
//   instructions accepted into IF/ID.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active high
//     bus   fetch_ctrl_if.slave (see interface for the signal list)
//   All decode is combinational from the current inputs: stall/redirect reach
//   next_pc and ifid_* in the same cycle.
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          PC_WIDTH     = PC_WIDTH_DEF,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] HALT_CODE    = HALT_CODE_DEF,
    parameter int          CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);

    // Extra flush cycles after the redirect cycle itself.
    localparam logic [2:0] DRAIN_LOAD = 3'(FLUSH_CYCLES - 1);

    fetch_state_t         r_state;
    logic [2:0]           r_drain_cnt;
    logic [CNT_WIDTH-1:0] r_fetch_count;
    logic                 r_halted;

    fetch_state_t         w_state_next;
    logic [2:0]           w_drain_next;
    logic [PC_WIDTH-1:0]  w_next_pc;
    logic                 w_ifid_write;
    logic                 w_ifid_flush;
    logic                 w_redirect;
    logic [PC_WIDTH-1:0]  w_target;

    // Branch is from the older instruction (EX), so it beats a same-cycle
    // jump from ID. Targets are forced to a word boundary.
    assign w_redirect = bus.branch_req | bus.jump_req;
    assign w_target   = bus.branch_req ? {bus.branch_target[PC_WIDTH-1:2], 2'b00}
                                       : {bus.jump_target[PC_WIDTH-1:2], 2'b00};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= '0;
            r_fetch_count <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_next;
            // HALT is only left through reset, so this flag stays set.
            r_halted    <= (w_state_next == ST_HALT);
            if (w_ifid_write && (r_fetch_count != {CNT_WIDTH{1'b1}})) begin
                r_fetch_count <= r_fetch_count + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / output decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_drain_next = r_drain_cnt;
        w_next_pc    = bus.PCnext;
        w_ifid_write = 1'b0;
        w_ifid_flush = 1'b0;

        unique case (r_state)
            ST_RUN, ST_STALL: begin
                // STALL decodes exactly like RUN; it only records that the
                // previous cycle was held.
                if (w_redirect) begin
                    w_next_pc    = w_target;
                    w_ifid_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_next = ST_DRAIN;
                        w_drain_next = DRAIN_LOAD;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end else if (bus.stall) begin
                    w_next_pc    = bus.PCout;
                    w_state_next = ST_STALL;
                end else if (bus.Instruction == HALT_CODE) begin
                    // The HALT word itself still enters the pipeline.
                    w_next_pc    = bus.PCout;
                    w_ifid_write = 1'b1;
                    w_state_next = ST_HALT;
                end else begin
                    w_next_pc    = bus.PCnext;
                    w_ifid_write = 1'b1;
                    w_state_next = ST_RUN;
                end
            end

            ST_DRAIN: begin
                // Everything fetched here is wrong-path, so HALT detect is
                // skipped and IF/ID keeps being cleared.
                w_ifid_flush = 1'b1;
                if (w_redirect) begin
                    w_next_pc    = w_target;
                    w_drain_next = DRAIN_LOAD;
                end else if (bus.stall) begin
                    w_next_pc = bus.PCout;
                end else begin
                    w_next_pc    = bus.PCnext;
                    w_drain_next = r_drain_cnt - 3'd1;
                    if (r_drain_cnt <= 3'd1) begin
                        w_state_next = ST_RUN;
                    end
                end
            end

            ST_HALT: begin
                w_next_pc    = bus.PCout;
                w_ifid_flush = 1'b1;
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // While reset is held the IF stage is pointed at address 0 and IF/ID
        // is kept clear.
        if (rst) begin
            w_next_pc    = '0;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
        end
    end

    assign bus.next_pc     = w_next_pc;
    assign bus.ifid_write  = w_ifid_write;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.fetch_valid = w_ifid_write;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_fetch_count;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl. The bench plays the IF stage: a PC register
//   that loads next_pc every edge, PCnext = PCout + 4, and an instruction
//   source that returns HALT_CODE at one address when enabled, 0 otherwise.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   5 units after the edge.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int          PCW  = 6;
    localparam int          CNTW = 16;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halt_en = 1'b0;
    logic [PCW-1:0] halt_addr = 6'h0C;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_ctrl_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CNTW)) fif ();

    fetch_ctrl #(
        .PC_WIDTH     (PCW),
        .FLUSH_CYCLES (3),
        .HALT_CODE    (HALT),
        .CNT_WIDTH    (CNTW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    always #5 clk = ~clk;

    // IF stage model
    always @(posedge clk) fif.PCout <= fif.next_pc;
    assign fif.PCnext      = fif.PCout + 6'd4;
    assign fif.Instruction = (halt_en && (fif.PCout == halt_addr)) ? HALT : 32'h0000_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic chk_ctl(input string tag, input logic [PCW-1:0] npc,
                           input logic wr, input logic fl);
        check({tag, ".next_pc"},     32'(fif.next_pc),     32'(npc));
        check({tag, ".ifid_write"},  32'(fif.ifid_write),  32'(wr));
        check({tag, ".ifid_flush"},  32'(fif.ifid_flush),  32'(fl));
        check({tag, ".fetch_valid"}, 32'(fif.fetch_valid), 32'(wr));
    endtask

    initial begin
        fif.stall         = 1'b0;
        fif.jump_req      = 1'b0;
        fif.jump_target   = '0;
        fif.branch_req    = 1'b0;
        fif.branch_target = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk_ctl("rst", 6'h00, 1'b0, 1'b1);
        check("rst.fetch_count", 32'(fif.fetch_count), 32'd0);
        check("rst.halted",      32'(fif.halted),      32'd0);

        // ---- straight-line 20 cycles with wrap ----
        next_cyc();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            chk_ctl($sformatf("seq%0d", i), PCW'((i + 1) * 4), 1'b1, 1'b0);
            next_cyc();
        end
        settle();
        check("seq.fetch_count", 32'(fif.fetch_count), 32'd20);
        check("seq.pc_after",    32'(fif.next_pc),     32'h14);

        // ---- reset mid-run at PC=0x10 ----
        rst = 1'b1;
        #1;
        chk_ctl("midrst", 6'h00, 1'b0, 1'b1);
        check("midrst.fetch_count", 32'(fif.fetch_count), 32'd0);
        next_cyc();
        rst = 1'b0;
        settle();
        chk_ctl("postrst", 6'h04, 1'b1, 1'b0);
        next_cyc();
        settle();
        chk_ctl("postrst2", 6'h08, 1'b1, 1'b0);
        next_cyc();

        // ---- stall 3 cycles at PC=0x08 ----
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_ctl($sformatf("stall%0d", i), 6'h08, 1'b0, 1'b0);
            check($sformatf("stall%0d.fetch_count", i), 32'(fif.fetch_count), 32'd2);
            next_cyc();
        end
        fif.stall = 1'b0;
        settle();
        chk_ctl("unstall", 6'h0C, 1'b1, 1'b0);
        next_cyc();

        // ---- branch + jump same cycle, 3-cycle flush ----
        fif.branch_req    = 1'b1;
        fif.branch_target = 6'h20;
        fif.jump_req      = 1'b1;
        fif.jump_target   = 6'h30;
        settle();
        chk_ctl("redir", 6'h20, 1'b0, 1'b1);
        next_cyc();
        fif.branch_req = 1'b0;
        fif.jump_req   = 1'b0;
        settle();
        chk_ctl("drain1", 6'h24, 1'b0, 1'b1);
        next_cyc();
        settle();
        chk_ctl("drain2", 6'h28, 1'b0, 1'b1);
        next_cyc();
        settle();
        chk_ctl("drain_done", 6'h2C, 1'b1, 1'b0);
        check("drain_done.fetch_count", 32'(fif.fetch_count), 32'd3);
        next_cyc();

        // ---- branch during stall, unaligned target; stall freezes drain ----
        fif.stall         = 1'b1;
        fif.branch_req    = 1'b1;
        fif.branch_target = 6'h17;
        settle();
        chk_ctl("brstall", 6'h14, 1'b0, 1'b1);
        next_cyc();
        fif.branch_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk_ctl($sformatf("drainstall%0d", i), 6'h14, 1'b0, 1'b1);
            next_cyc();
        end
        fif.stall = 1'b0;
        settle();
        chk_ctl("drainres1", 6'h18, 1'b0, 1'b1);
        next_cyc();
        settle();
        chk_ctl("drainres2", 6'h1C, 1'b0, 1'b1);
        next_cyc();
        settle();
        chk_ctl("drainres_run", 6'h20, 1'b1, 1'b0);
        check("drainres_run.fetch_count", 32'(fif.fetch_count), 32'd4);

        // ---- HALT at 0x0C ----
        rst     = 1'b1;
        halt_en = 1'b1;
        next_cyc();
        rst = 1'b0;
        settle();
        chk_ctl("hrun0", 6'h04, 1'b1, 1'b0);
        next_cyc();
        next_cyc();
        next_cyc();
        settle();
        chk_ctl("hdetect", 6'h0C, 1'b1, 1'b0);
        check("hdetect.halted", 32'(fif.halted), 32'd0);
        next_cyc();
        fif.jump_req    = 1'b1;
        fif.jump_target = 6'h30;
        settle();
        chk_ctl("halt1", 6'h0C, 1'b0, 1'b1);
        check("halt1.halted",      32'(fif.halted),      32'd1);
        check("halt1.fetch_count", 32'(fif.fetch_count), 32'd4);
        next_cyc();
        fif.jump_req = 1'b0;
        settle();
        chk_ctl("halt2", 6'h0C, 1'b0, 1'b1);
        check("halt2.halted",      32'(fif.halted),      32'd1);
        check("halt2.fetch_count", 32'(fif.fetch_count), 32'd4);
        rst = 1'b1;
        #1;
        check("haltrst.halted", 32'(fif.halted), 32'd0);
        halt_en = 1'b0;
        next_cyc();
        rst = 1'b0;
        settle();
        chk_ctl("haltrst_run", 6'h04, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected finish before t=20000");
        $fatal(1);
    end

endmodule : tb_fetch_ctrl
